// File: rtl/rr_arbiter.sv
// N-way request/grant arbiter with a registered one-hot grant, round-robin or fixed
// priority selection, and an optional hold limit that forces rotation.
module rr_arbiter #(
    parameter int N             = 4,
    parameter int IDX_W         = 2,
    parameter int PRIORITY_MODE = 0,
    parameter int HOLD_MAX      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic             dbg_state_o
);

    localparam int HC_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [HC_W-1:0]  hold_q, hold_d;

    logic [N-1:0]     others;
    logic             owner_req;
    logic             limit_hit;
    logic [N-1:0]     arb_mask;
    logic             arb_found;
    logic [IDX_W-1:0] arb_win;
    logic [IDX_W-1:0] scan;
    logic             new_grant;

    // At the hold limit the current owner is masked out so a waiting channel wins.
    always_comb begin
        others    = req & ~grant_q;
        owner_req = |(req & grant_q);
        limit_hit = (state_q == GRANT) && (HOLD_MAX > 0) && (hold_q == HOLD_LIM) && owner_req;
        arb_mask  = limit_hit ? others : req;
    end

    always_comb begin
        arb_found = 1'b0;
        arb_win   = '0;
        scan      = '0;
        for (int k = 0; k < N; k++) begin
            if (PRIORITY_MODE == 1) scan = IDX_W'(k);
            else                    scan = IDX_W'((int'(ptr_q) + k) % N);
            if (!arb_found && arb_mask[scan]) begin
                arb_found = 1'b1;
                arb_win   = scan;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        new_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) new_grant = 1'b1;
            end
            GRANT: begin
                if (!owner_req) begin
                    if (|req) begin
                        new_grant = 1'b1;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        idx_d   = '0;
                        hold_d  = '0;
                    end
                end else if (HOLD_MAX == 0 || hold_q != HOLD_LIM) begin
                    hold_d = hold_q + 1'b1;
                end else if (|others) begin
                    new_grant = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (new_grant && arb_found) begin
            state_d          = GRANT;
            grant_d          = '0;
            grant_d[arb_win] = 1'b1;
            idx_d            = arb_win;
            hold_d           = '0;
            if (PRIORITY_MODE == 0)
                ptr_d = (int'(arb_win) == N - 1) ? '0 : arb_win + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = |grant_q;
    assign grant_idx   = idx_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Bench for rr_arbiter: a round-robin instance with a hold limit of 4 and a
// fixed-priority instance with no limit, both checked against a behavioural model.
module tb_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req_rr, req_fp;
    logic [3:0] grant_rr, grant_fp;
    logic       valid_rr, valid_fp;
    logic [1:0] idx_rr, idx_fp;
    logic       st_rr, st_fp;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_rr_q[$];
    logic [7:0] exp_fp_q[$];

    int g_rr, p_rr, h_rr;
    int g_fp, p_fp, h_fp;

    rr_arbiter #(.N(4), .IDX_W(2), .PRIORITY_MODE(0), .HOLD_MAX(4)) u_rr (
        .clk(clk), .rst(rst), .req(req_rr), .grant(grant_rr),
        .grant_valid(valid_rr), .grant_idx(idx_rr), .dbg_state_o(st_rr)
    );

    rr_arbiter #(.N(4), .IDX_W(2), .PRIORITY_MODE(1), .HOLD_MAX(0)) u_fp (
        .clk(clk), .rst(rst), .req(req_fp), .grant(grant_fp),
        .grant_valid(valid_fp), .grant_idx(idx_fp), .dbg_state_o(st_fp)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] enc(input int g);
        logic [3:0] oh;
        if (g < 0) return 8'h00;
        oh = 4'b0001 << g;
        return {oh, 1'b1, 2'(g), 1'b1};
    endfunction

    task automatic model_reset();
        g_rr = -1; p_rr = 0; h_rr = 0;
        g_fp = -1; p_fp = 0; h_fp = 0;
    endtask

    task automatic model_step(input int mode, input int hmax, input logic [3:0] r,
                              inout int g, inout int ptr, inout int hold);
        logic [3:0] m;
        int w;
        bit pick;
        pick = 1'b0;
        m    = r;
        if (g < 0) begin
            pick = (r != 0);
        end else if (!r[g]) begin
            if (r != 0) pick = 1'b1;
            else begin g = -1; hold = 0; end
        end else if (hmax == 0 || hold < hmax - 1) begin
            hold++;
        end else begin
            m[g] = 1'b0;
            pick = (m != 0);
        end
        if (pick) begin
            w = -1;
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (mode == 1) ? k : (ptr + k) % 4;
                if (w < 0 && m[j]) w = j;
            end
            g    = w;
            hold = 0;
            if (mode == 0) ptr = (w + 1) % 4;
        end
    endtask

    // driver: apply one request pair, predict, then compare after the edge
    task automatic step(input logic [3:0] r_rr, input logic [3:0] r_fp);
        req_rr = r_rr;
        req_fp = r_fp;
        model_step(0, 4, r_rr, g_rr, p_rr, h_rr);
        exp_rr_q.push_back(enc(g_rr));
        model_step(1, 0, r_fp, g_fp, p_fp, h_fp);
        exp_fp_q.push_back(enc(g_fp));
        @(negedge clk);
        if (exp_rr_q.size() == 0 || exp_fp_q.size() == 0) begin
            check_eq("queue_empty", 32'd0, 32'd1);
        end else begin
            check_eq("rr_out", {24'd0, grant_rr, valid_rr, idx_rr, st_rr}, {24'd0, exp_rr_q.pop_front()});
            check_eq("fp_out", {24'd0, grant_fp, valid_fp, idx_fp, st_fp}, {24'd0, exp_fp_q.pop_front()});
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst    = 1'b1;
        req_rr = 4'b1111;
        req_fp = 4'b1111;
        model_reset();

        // reset held with all requests high
        repeat (3) begin
            @(negedge clk);
            check_eq("rst_grant_rr", {28'd0, grant_rr}, 32'd0);
            check_eq("rst_valid_rr", {31'd0, valid_rr}, 32'd0);
            check_eq("rst_idx_rr",   {30'd0, idx_rr},   32'd0);
            check_eq("rst_grant_fp", {28'd0, grant_fp}, 32'd0);
        end
        rst = 1'b0;

        // release hands over with no idle cycle
        step(4'b1011, 4'b0000);
        check_eq("t2_grant0", {28'd0, grant_rr}, 32'b0001);
        check_eq("t2_idx0",   {30'd0, idx_rr},   32'd0);
        step(4'b1010, 4'b0000);
        check_eq("t2_grant1", {28'd0, grant_rr}, 32'b0010);
        check_eq("t2_idx1",   {30'd0, idx_rr},   32'd1);
        step(4'b0000, 4'b0000);
        check_eq("t2_idle", {31'd0, valid_rr}, 32'd0);

        // hold limit rotation with all requests pending
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(4'b1111, 4'b0000);
            check_eq("t3_rot", {28'd0, grant_rr}, 32'(4'b0001 << ((i / 4) % 4)));
        end

        // fixed priority: held grant is not pre-empted by a higher priority request
        do_reset();
        step(4'b0000, 4'b1000);
        check_eq("t4_first", {28'd0, grant_fp}, 32'b1000);
        repeat (3) begin
            step(4'b0000, 4'b1010);
            check_eq("t4_hold", {28'd0, grant_fp}, 32'b1000);
        end
        step(4'b0000, 4'b0010);
        check_eq("t4_next", {28'd0, grant_fp}, 32'b0010);

        // lone requester is never pre-empted
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(4'b0100, 4'b0000);
            check_eq("t5_lone", {28'd0, grant_rr}, 32'b0100);
        end

        // asynchronous reset mid-grant clears grant and pointer
        do_reset();
        step(4'b1111, 4'b0001);
        step(4'b1110, 4'b0001);
        check_eq("t6_pre", {28'd0, grant_rr}, 32'b0010);
        #2 rst = 1'b1;
        #1;
        check_eq("t6_async_grant", {28'd0, grant_rr}, 32'd0);
        check_eq("t6_async_valid", {31'd0, valid_rr}, 32'd0);
        check_eq("t6_async_fp",    {28'd0, grant_fp}, 32'd0);
        #1 rst = 1'b0;
        model_reset();
        step(4'b1111, 4'b0000);
        check_eq("t6_ptr_reset", {28'd0, grant_rr}, 32'b0001);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
